// File: rtl/morse_tx.sv
// morse_tx: keys one Morse character (1..5 dots/dashes) or a word gap, timed in units of UNIT_CYCLES clocks
module morse_tx #(
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] sym_len,
  input  logic [4:0] sym_bits,
  input  logic       space,
  input  logic       abort,
  output logic       key,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] elem_idx
);
  typedef enum logic [2:0] {IDLE, MARK, GAP_ELEM, GAP_CHAR, GAP_WORD} state_t;
  localparam logic [25:0] UNIT_LAST = 26'(UNIT_CYCLES - 1);
  state_t      state, state_n;
  logic [25:0] cyc_cnt;
  logic [2:0]  unit_cnt, len_q, last_unit, bit_sel;
  logic [4:0]  bits_q;
  logic [7:0]  bits_x;
  logic        unit_end, state_end, invalid, accept, cur_dash;
  assign busy = state != IDLE;
  always_comb begin
    bits_x    = {3'b000, bits_q};
    bit_sel   = len_q - 3'd1 - elem_idx;
    cur_dash  = bits_x[bit_sel];
    unit_end  = cyc_cnt == UNIT_LAST;
    last_unit = state == MARK     ? (cur_dash ? 3'd2 : 3'd0) :
                state == GAP_CHAR ? 3'd2 :
                state == GAP_WORD ? 3'd6 : 3'd0;
    state_end = unit_end && unit_cnt == last_unit;
    invalid   = sym_len == 3'd0 || sym_len > 3'd5;
    accept    = state == IDLE && start && !abort && !space && !invalid;
    state_n   = state;
    unique case (state)
      IDLE:     state_n = (start && space) ? GAP_WORD : accept ? MARK : IDLE;
      MARK:     if (state_end) state_n = (elem_idx == len_q - 3'd1) ? GAP_CHAR : GAP_ELEM;
      GAP_ELEM: if (state_end) state_n = MARK;
      GAP_CHAR, GAP_WORD: if (state_end) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      key      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      elem_idx <= 3'd0;
      cyc_cnt  <= 26'd0;
      unit_cnt <= 3'd0;
      len_q    <= 3'd0;
      bits_q   <= 5'd0;
    end else begin
      state    <= state_n;
      key      <= state_n == MARK;
      done     <= (state == GAP_CHAR || state == GAP_WORD) && state_n == IDLE && !abort;
      err      <= state == IDLE && start && !space && invalid && !abort;
      elem_idx <= state_n == IDLE ? 3'd0 :
                  (state == GAP_ELEM && state_n == MARK) ? elem_idx + 3'd1 : elem_idx;
      // counters restart on every state entry so each state times from zero
      if (state_n != state || state == IDLE) begin
        cyc_cnt  <= 26'd0;
        unit_cnt <= 3'd0;
      end else begin
        cyc_cnt  <= unit_end ? 26'd0 : cyc_cnt + 26'd1;
        unit_cnt <= unit_end ? unit_cnt + 3'd1 : unit_cnt;
      end
      if (accept) begin
        len_q  <= sym_len;
        bits_q <= sym_bits;
      end
    end
  end
endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx: scoreboard bench; key runs, done and err events are compared against hand-computed queues
module tb_morse_tx;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, space = 1'b0, abort = 1'b0;
  logic [2:0] sym_len = 3'd0;
  logic [4:0] sym_bits = 5'd0;
  logic       key, busy, done, err;
  logic [2:0] elem_idx;
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  logic cur_key;
  int run_len = 0, run_idx = 0;

  morse_tx #(.UNIT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sym_len(sym_len), .sym_bits(sym_bits),
    .space(space), .abort(abort), .key(key), .busy(busy), .done(done), .err(err),
    .elem_idx(elem_idx)
  );

  always #5 clk = ~clk;

  // event word: kind (0 space run, 1 mark run, 2 done, 3 err), element index, length
  function automatic logic [31:0] ev(int kind, int idx, int len);
    return {4'(kind), 4'(idx), 24'(len)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic emit(logic [31:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got %h expected none", act);
    end else check("event", act, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (busy) begin
      if (run_len == 0) begin
        cur_key = key; run_len = 1; run_idx = int'(elem_idx);
      end else if (key == cur_key) run_len++;
      else begin
        emit(ev(int'(cur_key), run_idx, run_len));
        cur_key = key; run_len = 1; run_idx = int'(elem_idx);
      end
    end else if (run_len != 0) begin
      emit(ev(int'(cur_key), run_idx, run_len));
      run_len = 0;
    end
    if (done) emit(ev(2, 0, 0));
    if (err) emit(ev(3, 0, {busy, key}));
  end

  task automatic send(logic sp, logic [2:0] len, logic [4:0] bits);
    @(negedge clk);
    start = 1'b1; space = sp; sym_len = len; sym_bits = bits;
    @(negedge clk);
    start = 1'b0; space = 1'b0;
  endtask

  task automatic wait_done(string name);
    logic seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({"done_seen_", name}, 32'(seen), 32'd1);
  endtask

  task automatic push_e();
    exp_q.push_back(ev(1, 0, 4));
    exp_q.push_back(ev(0, 0, 12));
    exp_q.push_back(ev(2, 0, 0));
  endtask

  initial begin
    #12;
    check("rst_key", 32'(key), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_idx", 32'(elem_idx), 32'd0);
    @(negedge clk) reset = 1'b0;
    // 'E': one dot
    push_e();
    send(1'b0, 3'd1, 5'b00000);
    wait_done("E");
    // 'K': dash dot dash
    exp_q.push_back(ev(1, 0, 12)); exp_q.push_back(ev(0, 0, 4));
    exp_q.push_back(ev(1, 1, 4));  exp_q.push_back(ev(0, 1, 4));
    exp_q.push_back(ev(1, 2, 12)); exp_q.push_back(ev(0, 2, 12));
    exp_q.push_back(ev(2, 0, 0));
    send(1'b0, 3'd3, 5'b00101);
    wait_done("K");
    // word gap, then 'E' started during the done cycle
    exp_q.push_back(ev(0, 0, 28)); exp_q.push_back(ev(2, 0, 0));
    push_e();
    send(1'b1, 3'd0, 5'b00000);
    wait_done("word");
    start = 1'b1; sym_len = 3'd1; sym_bits = 5'b00000;
    @(negedge clk);
    start = 1'b0;
    check("b2b_key", 32'(key), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b");
    // invalid lengths
    exp_q.push_back(ev(3, 0, 0));
    send(1'b0, 3'd0, 5'b10101);
    repeat (2) @(negedge clk);
    exp_q.push_back(ev(3, 0, 0));
    send(1'b0, 3'd7, 5'b11111);
    repeat (2) @(negedge clk);
    exp_q.push_back(ev(3, 0, 0));
    send(1'b0, 3'd6, 5'b00000);
    repeat (2) @(negedge clk);
    check("inv_busy", 32'(busy), 32'd0);
    // 'A' (dot dash) with starts issued while busy
    exp_q.push_back(ev(1, 0, 4));  exp_q.push_back(ev(0, 0, 4));
    exp_q.push_back(ev(1, 1, 12)); exp_q.push_back(ev(0, 1, 12));
    exp_q.push_back(ev(2, 0, 0));
    send(1'b0, 3'd2, 5'b00001);
    repeat (3) @(negedge clk);
    send(1'b0, 3'd1, 5'b11111);
    send(1'b1, 3'd0, 5'b00000);
    wait_done("A");
    // abort mid-dash
    exp_q.push_back(ev(1, 0, 5));
    send(1'b0, 3'd1, 5'b00001);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_key", 32'(key), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    push_e();
    send(1'b0, 3'd1, 5'b00000);
    wait_done("after_abort");
    // abort beats start in the same cycle
    @(negedge clk);
    abort = 1'b1; start = 1'b1; sym_len = 3'd1; sym_bits = 5'b00000;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_prio_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort_prio_key", 32'(key), 32'd0);
    // async reset mid-dash
    exp_q.push_back(ev(1, 0, 5));
    send(1'b0, 3'd1, 5'b00001);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_key", 32'(key), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk) reset = 1'b0;
    push_e();
    send(1'b0, 3'd1, 5'b00000);
    wait_done("after_reset");
    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
